// File: rtl/key_pkg.sv
// Shared types and helpers for the key debounce front end.
`timescale 1ns/1ps
package key_pkg;

   localparam int NUM_KEYS = 8;

   typedef logic [2:0] key_idx_t;
   typedef logic [3:0] press_cnt_t;

   // Highest set bit wins, matching the encoder's priority rule.
   function automatic key_idx_t hi_index(input logic [NUM_KEYS-1:0] v);
      key_idx_t idx;
      idx = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (v[i]) idx = key_idx_t'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/debounce_bit.sv
// One key lane: 2-flop synchroniser, tick-sampled history, stable level.
`timescale 1ns/1ps
module debounce_bit #(
   parameter int DEBOUNCE_LEN = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic tick,
   input  logic sw_raw,
   output logic level,
   output logic level_nxt
);

   logic                    sync1;
   logic                    s;
   logic [DEBOUNCE_LEN-2:0] hist;
   logic [DEBOUNCE_LEN-1:0] window;

   // The newest sample joins the stored history for the equality test.
   assign window = {hist, s};

   // Two-flop synchroniser for the asynchronous raw level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         s     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so s takes the old sync1, forming a real two-stage chain.
         sync1 <= sw_raw;
         s     <= sync1;
      end
   end

   // Next stable level: changes only on a tick with a full window of equal samples.
   always_comb begin
      // NOTE: default first so every path assigns level_nxt and no latch is inferred.
      level_nxt = level;
      if (tick) begin
         if (&window)       level_nxt = 1'b1;
         else if (~|window) level_nxt = 1'b0;
      end
   end

   // History shift register and stable-level flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: history is reset on purpose so a held key re-qualifies from empty after reset.
         hist  <= '0;
         level <= 1'b0;
      end else begin
         if (tick) hist <= window[DEBOUNCE_LEN-2:0];
         level <= level_nxt;
      end
   end

endmodule

// File: rtl/key_debounce8.sv
// Eight-key debounce front end with press detection for the encoder path.
`timescale 1ns/1ps
module key_debounce8
   import key_pkg::*;
#(
   parameter int TICK_DIV     = 50000,
   parameter int DEBOUNCE_LEN = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_KEYS-1:0] sw_raw,
   output logic [NUM_KEYS-1:0] x,
   output logic                en,
   output logic                press_valid,
   output key_idx_t            press_idx,
   output press_cnt_t          press_cnt
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0]       div_cnt;
   logic                tick;
   logic [NUM_KEYS-1:0] x_nxt;
   logic [NUM_KEYS-1:0] x_prev;
   logic [NUM_KEYS-1:0] rise;

   assign tick = (div_cnt == CW'(TICK_DIV - 1));
   assign rise = x & ~x_prev;

   // Prescaler: counts 0..TICK_DIV-1 and wraps, one tick per period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    div_cnt <= '0;
      else if (tick) div_cnt <= '0;
      else           div_cnt <= div_cnt + CW'(1);
   end

   genvar g;
   generate
      for (g = 0; g < NUM_KEYS; g++) begin : g_key
         debounce_bit #(
            .DEBOUNCE_LEN (DEBOUNCE_LEN)
         ) u_bit (
            .clk       (clk),
            .rst_n     (rst_n),
            .tick      (tick),
            .sw_raw    (sw_raw[g]),
            .level     (x[g]),
            .level_nxt (x_nxt[g])
         );
      end
   endgenerate

   // Enable follows the same edge as x; previous x kept for rise detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en     <= 1'b0;
         x_prev <= '0;
      end else begin
         en     <= |x_nxt;
         x_prev <= x;
      end
   end

   // Press event: one pulse per update with any rise, highest risen key, count +1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         press_valid <= 1'b0;
         press_idx   <= '0;
         press_cnt   <= '0;
      end else begin
         press_valid <= |rise;
         if (|rise) begin
            press_idx <= hi_index(rise);
            press_cnt <= press_cnt + press_cnt_t'(1);
         end
      end
   end

endmodule

// File: doc/key_debounce8.md
# key_debounce8

Front-end input conditioner for the 8-to-3 encoder / seven-segment path. It synchronises and debounces eight raw board switches or keys, then presents a clean 8-bit vector and an enable to the encoder. It also flags each new key press and records which key was pressed and how many presses have occurred. It sits between the board I/O pins and the encoder input.

## Interface
Parameters:
- `TICK_DIV`, 50000: clock cycles per debounce sample tick; must be at least 2.
- `DEBOUNCE_LEN`, 4: consecutive equal samples required to accept a new level; range 2..8.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `sw_raw`  in  8  raw switch/key levels; asynchronous to `clk`.
- `x`  out  8  debounced stable levels; drives the encoder data input.
- `en`  out  1  high when any bit of `x` is 1; drives the encoder enable.
- `press_valid`  out  1  one-cycle pulse on a new press.
- `press_idx`  out  3  index of the highest-numbered key in the most recent press event; held between events.
- `press_cnt`  out  4  count of press events, modulo 16.

## Operation
- **Synchroniser:** each `sw_raw` bit passes through a 2-flop synchroniser. The value at the second flop is `s`.
- **Prescaler:** counter runs 0..`TICK_DIV`-1 and wraps. `tick` is high during the cycle the counter equals `TICK_DIV`-1.
- **History register:** each bit keeps a `DEBOUNCE_LEN`-deep shift history of `s`. The history shifts only on `tick`.
- **Stable-level update:** on a `tick` cycle, if all `DEBOUNCE_LEN` samples of bit i (including the one being shifted in) equal v and v != `x[i]`, then `x[i]` takes v at that clock edge. Otherwise `x[i]` holds.
- **Enable:** `en` = OR of `x`, registered in the same cycle as `x`.
- **Press detection:** a rise is a bit going 0->1 in `x`. In the cycle after any rise:
  - `press_valid` = 1.
  - `press_idx` = highest index i among the bits that rose on that update.
  - `press_cnt` increments by exactly 1, even when several bits rose together.
- **Releases:** 1->0 changes update `x` and `en` only. No pulse; `press_idx` and `press_cnt` are unchanged.
- **Wrap:** `press_cnt` goes from 15 to 0.
- **Glitch rejection:** a level that flips back before `DEBOUNCE_LEN` consecutive equal samples leaves `x` unchanged.
- **Reset values:** synchronisers, history, `x`, `en`, `press_valid`, `press_idx` and `press_cnt` all reset to 0. The prescaler resets to 0.
- **Reset mid-operation:** all state clears immediately. After reset, keys that are still held are re-qualified from empty history and produce a fresh press event.

## Timing
- **Latency:** a clean step on `sw_raw` appears on `x` at most 2 + `TICK_DIV`*`DEBOUNCE_LEN` cycles after the step. It appears no sooner than 2 + `TICK_DIV`*(`DEBOUNCE_LEN`-1) + 1 cycles after the step.
- **Press pulse:** `press_valid`, `press_idx` and `press_cnt` update exactly 1 cycle after the `x` rise.
- **Pulse spacing:** `press_valid` is high for exactly 1 cycle. Two consecutive press events are at least `TICK_DIV` cycles apart.
- **Output registers:** all outputs are registered. There are no combinational paths from `sw_raw` to any output.

## Structure
- **Shared package `key_pkg`:**
  - `NUM_KEYS` = 8.
  - `key_idx_t` (3-bit).
  - `press_cnt_t` (4-bit).
  - Helper function `hi_index(8-bit)`, returning the highest set bit index. This uses the same priority rule as the encoder.
- **Sub-module `debounce_bit`:**
  - Contains the synchroniser, history and stable-level flop for one bit.
  - Instantiated 8 times with a generate loop.
  - Shares the one `tick` from the top level.
- **Top level:** contains the prescaler, the rise detect (`x` & ~`x_prev`), index select and counter.

## Test plan
Use `TICK_DIV`=4 and `DEBOUNCE_LEN`=3 for all scenarios.

1. **Reset:** hold `rst_n`=0 with `sw_raw`=8'hFF.
   - Required: `x`=0, `en`=0, `press_cnt`=0 throughout.
   - After release: `x` becomes 8'hFF within 14 cycles, then one `press_valid` with `press_idx`=7 and `press_cnt`=1.
2. **Clean press:** step `sw_raw` from 0 to 8'h04 and hold.
   - Required: `x`=8'h04 and `en`=1 within 14 cycles.
   - One `press_valid` with `press_idx`=2 and `press_cnt`=1.
3. **Bounce:** toggle bit 5 every 3 cycles for 40 cycles, then hold at 1.
   - Required: no `x` change during the toggling.
   - Exactly one press with `press_idx`=5 after settling.
4. **Simultaneous press:** step 8'h00 to 8'h12 in the same cycle.
   - Required: a single `press_valid`, `press_idx`=4, `press_cnt` +1.
5. **Release:** drop from 8'h12 to 8'h00.
   - Required: `x`=0 and `en`=0 within 14 cycles, no `press_valid`, `press_idx` held at 4.
6. **Counter wrap and mid-operation reset:**
   - 17 press/release cycles on bit 0: required `press_cnt` reads 1 after the 17th press.
   - Assert `rst_n` mid-qualification: required all outputs are 0 in the same cycle.
